// File: rtl/pcie_traffic_gen.sv
// pcie_traffic_gen: start-triggered framed PCIe lane traffic generator (TS1-TS4, header, payload, EOP); define PCIE_TRAFFIC_LFSR_EN to add the LFSR payload mode
module pcie_traffic_gen #(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 8,
  parameter int TRAIN_REPS = 1,
  parameter int SEQ_W      = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic              ready,
  output logic [3:0]        CONTROL,
  output logic [DATA_W-1:0] DATA,
  output logic              Valid,
  output logic              busy,
  output logic              done
);
  localparam int RW = $clog2(TRAIN_REPS + 1);
  localparam logic [2:0] IDLE = 3'd0, TRAIN = 3'd1, HDR = 3'd2, PAY = 3'd3, EOP = 3'd4;
  logic [2:0] st, st_n;
  logic [1:0] ts, ts_n;
  logic [RW-1:0] rep, rep_n;
  logic [LEN_W-1:0] cnt, cnt_n, len_r, len_n;
  logic [DATA_W-1:0] inc, inc_n, pay_d, data_n;
  logic [SEQ_W-1:0] seq, seq_n;
  logic [3:0] ctl_n;
  logic fix, fix_n, done_n, fire;
`ifdef PCIE_TRAFFIC_LFSR_EN
  logic [15:0] lfsr, lfsr_n;
  logic lfm, lfm_n;
`endif
  assign fire = Valid & ready;
  // next-state and next-output computation; outputs are derived from the next state so they can be registered
  always_comb begin
    st_n = st;
    ts_n = ts;
    rep_n = rep;
    cnt_n = cnt;
    len_n = len_r;
    inc_n = inc;
    fix_n = fix;
    seq_n = seq;
    done_n = 1'b0;
`ifdef PCIE_TRAFFIC_LFSR_EN
    lfsr_n = lfsr;
    lfm_n = lfm;
`endif
    case (st)
      IDLE: if (start) begin
        st_n = TRAIN;
        ts_n = '0;
        rep_n = '0;
        cnt_n = '0;
        len_n = len;
        inc_n = pattern;
        fix_n = mode[1];
`ifdef PCIE_TRAFFIC_LFSR_EN
        lfsr_n = 16'hACE1;
        lfm_n = mode == 2'b01;
`endif
      end
      TRAIN: if (fire) begin
        rep_n = (rep == RW'(TRAIN_REPS - 1)) ? '0 : rep + 1'b1;
        if (rep == RW'(TRAIN_REPS - 1)) begin
          ts_n = ts + 2'd1;
          st_n = (ts == 2'd3) ? HDR : TRAIN;
        end
      end
      HDR: if (fire) st_n = (len_r == '0) ? EOP : PAY;
      PAY: if (fire) begin
        cnt_n = cnt + 1'b1;
        inc_n = inc + DATA_W'(!fix);
`ifdef PCIE_TRAFFIC_LFSR_EN
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
        st_n = (cnt_n == len_r) ? EOP : PAY;
      end
      EOP: if (fire) begin
        st_n = IDLE;
        done_n = 1'b1;
        seq_n = seq + 1'b1;
      end
      default: st_n = IDLE;
    endcase
`ifdef PCIE_TRAFFIC_LFSR_EN
    pay_d = lfm_n ? lfsr_n[DATA_W-1:0] : inc_n;
`else
    pay_d = inc_n;
`endif
    ctl_n = st_n == TRAIN ? {2'b00, ts_n} + 4'd1 : st_n == HDR ? 4'h8 : st_n == PAY ? 4'h9 : st_n == EOP ? 4'hF : 4'h0;
    data_n = st_n == HDR ? DATA_W'(seq_n) : st_n == PAY ? pay_d : st_n == EOP ? DATA_W'(len_n) : '0;
  end
  // state and registered outputs; reset abandons any frame in flight
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      ts <= '0;
      rep <= '0;
      cnt <= '0;
      len_r <= '0;
      inc <= '0;
      fix <= 1'b0;
      seq <= '0;
      CONTROL <= 4'h0;
      DATA <= '0;
      Valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef PCIE_TRAFFIC_LFSR_EN
      lfsr <= 16'hACE1;
      lfm <= 1'b0;
`endif
    end else begin
      st <= st_n;
      ts <= ts_n;
      rep <= rep_n;
      cnt <= cnt_n;
      len_r <= len_n;
      inc <= inc_n;
      fix <= fix_n;
      seq <= seq_n;
      CONTROL <= ctl_n;
      DATA <= data_n;
      Valid <= st_n != IDLE;
      busy <= st_n != IDLE;
      done <= done_n;
`ifdef PCIE_TRAFFIC_LFSR_EN
      lfsr <= lfsr_n;
      lfm <= lfm_n;
`endif
    end
  end
endmodule

// File: tb/tb_pcie_traffic_gen.sv
// tb_pcie_traffic_gen: randomized frame-level bench for pcie_traffic_gen (8-bit/1-rep and 16-bit/2-rep instances side by side)
module tb_pcie_traffic_gen;
  typedef logic [19:0] beat_t;
  typedef beat_t bq_t[$];
  logic clk = 0, reset = 1, start = 0, ready = 1;
  logic [1:0] mode = 0;
  logic [7:0] len = 0, pat8 = 0, d8;
  logic [15:0] pat16 = 0, d16;
  logic [3:0] c8, c16;
  logic v8, v16, b8, b16, dn8, dn16;
  int vectors = 0, miscompares = 0;
  int seq = 0, dc8 = 0, dc16 = 0, vc8 = 0, vc16 = 0, cyc;
  bq_t a8, a16;
  logic [19:0] h8, h16;
  logic s8 = 0, s16 = 0;

  pcie_traffic_gen u8 (
    .CLK(clk), .reset(reset), .start(start), .mode(mode), .pattern(pat8), .len(len), .ready(ready),
    .CONTROL(c8), .DATA(d8), .Valid(v8), .busy(b8), .done(dn8)
  );
  pcie_traffic_gen #(.DATA_W(16), .TRAIN_REPS(2)) u16 (
    .CLK(clk), .reset(reset), .start(start), .mode(mode), .pattern(pat16), .len(len), .ready(ready),
    .CONTROL(c16), .DATA(d16), .Valid(v16), .busy(b16), .done(dn16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected accepted-beat list for one frame, straight from the framing rules
  function automatic bq_t build(input int dw, input int reps, input logic [1:0] m, input logic [15:0] p, input int n, input int sq);
    bq_t q;
    logic [15:0] lf = 16'hACE1;
    logic [15:0] msk = (dw == 16) ? 16'hFFFF : 16'h00FF;
    logic [15:0] d;
    bit lm = 0;
`ifdef PCIE_TRAFFIC_LFSR_EN
    lm = (m == 2'b01);
`endif
    for (int s = 1; s <= 4; s++)
      for (int r = 0; r < reps; r++) q.push_back({4'(s), 16'h0});
    q.push_back({4'h8, 16'(sq)});
    for (int k = 0; k < n; k++) begin
      d = m[1] ? p : lm ? lf : p + 16'(k);
      q.push_back({4'h9, d & msk});
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    q.push_back({4'hF, 16'(n) & msk});
    return q;
  endfunction

  // beat collector, stall-hold, busy/valid and done-pulse monitor
  always @(negedge clk) begin
    if (reset) begin
      if (s8) check("hold8", {c8, 8'h0, d8}, h8);
      if (s16) check("hold16", {c16, d16}, h16);
      if (v8 && ready) a8.push_back({c8, 8'h0, d8});
      if (v16 && ready) a16.push_back({c16, d16});
      vc8 += int'(v8);
      vc16 += int'(v16);
      if (dn8) begin dc8++; check("done8_idle", {b8, v8}, 0); end
      if (dn16) begin dc16++; check("done16_idle", {b16, v16}, 0); end
      check("busy8", b8, v8);
      check("busy16", b16, v16);
      s8 = v8 && !ready;
      s16 = v16 && !ready;
      h8 = {c8, 8'h0, d8};
      h16 = {c16, d16};
    end else begin
      s8 = 0;
      s16 = 0;
    end
  end

  task automatic run_frame(input logic [1:0] m, input logic [15:0] p, input int n, input bit bp, input bit extra);
    bq_t e8 = build(8, 1, m, p, n, seq);
    bq_t e16 = build(16, 2, m, p, n, seq);
    int c = 0;
    @(posedge clk); #1;
    a8 = {}; a16 = {}; dc8 = 0; dc16 = 0; vc8 = 0; vc16 = 0;
    mode = m; pat8 = p[7:0]; pat16 = p; len = 8'(n); start = 1; ready = 1;
    @(posedge clk); #1;
    start = 0; mode = 2'($urandom); pat8 = 8'($urandom); pat16 = 16'($urandom); len = 8'($urandom);
    while ((dc8 == 0 || dc16 == 0) && c < 500) begin
      ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = extra && b8 && b16 && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      c++;
    end
    start = 0; ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("timeout", c < 500, 1);
    check("beats8", a8.size(), e8.size());
    check("beats16", a16.size(), e16.size());
    foreach (e8[i]) if (i < a8.size()) check($sformatf("beat8[%0d]", i), a8[i], e8[i]);
    foreach (e16[i]) if (i < a16.size()) check($sformatf("beat16[%0d]", i), a16[i], e16[i]);
    check("dones8", dc8, 1);
    check("dones16", dc16, 1);
    if (!bp) begin
      check("cycles8", vc8, 6 + n);
      check("cycles16", vc16, 10 + n);
    end
    seq = (seq + 1) % 256;
  endtask

  initial begin
    #2 reset = 0;
    #1;
    check("reset8", {v8, b8, c8, d8, dn8}, 0);
    check("reset16", {v16, b16, c16, d16, dn16}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    run_frame(2'b00, 16'h00AA, 4, 0, 0);
    run_frame(2'b00, 16'h00AA, 4, 1, 0);
    run_frame(2'b01, 16'h0000, 3, 1, 0);
    run_frame(2'b00, 16'h0055, 0, 0, 0);
    run_frame(2'b00, 16'hFFFE, 3, 0, 0);
    run_frame(2'b10, 16'h5A5A, 5, 1, 1);
    repeat (6) run_frame(2'($urandom), 16'($urandom), int'($urandom_range(0, 20)), 1, 1);
    while (seq != 0) run_frame(2'b00, 16'h0000, 0, 0, 0);
    run_frame(2'b11, 16'h0011, 2, 0, 0);
    @(posedge clk); #1;
    dc8 = 0; dc16 = 0;
    mode = 0; pat8 = 8'h34; pat16 = 16'h1234; len = 8'd20; start = 1; ready = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (c8 !== 4'h9 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_pay", c8, 4'h9);
    #2 reset = 0;
    #1;
    check("midrst8", {v8, b8, c8, d8, dn8}, 0);
    check("midrst16", {v16, b16, c16, d16, dn16}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    check("midrst_nodone", dc8 + dc16, 0);
    seq = 0;
    run_frame(2'b00, 16'h0007, 2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pcie_traffic_gen.md
# pcie_traffic_gen

Synthesizable, parametrised successor to the PCIe-lane stimulus driver: generates complete framed lane traffic (training symbols, header, payload, end-of-packet) on a CONTROL/DATA/Valid bus with ready backpressure. It sits upstream of the PCIe transmit path under test, or in loopback self-test, and replaces hand-timed stimulus with a start-triggered frame engine. Payload width, training repetition and payload mode are configurable.

## Interface
- DATA_W, 8, payload/data bus width; legal values 8 or 16.
- LEN_W, 8, width of the payload-length input.
- TRAIN_REPS, 1, beats per training symbol (at least 1).
- SEQ_W, 8, header sequence-number width (at most DATA_W).

- CLK  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- start  input  1  single-cycle frame request; honoured only in IDLE.
- mode  input  2  payload mode: 00 increment, 01 LFSR, 10/11 fixed.
- pattern  input  DATA_W  payload seed or constant.
- len  input  LEN_W  payload beat count; 0 is legal.
- ready  input  1  downstream accept.
- CONTROL  output  4  symbol code: 0 idle, 1–4 TS1–TS4, 8 header, 9 data, 0xF EOP.
- DATA  output  DATA_W  beat data.
- Valid  output  1  beat present.
- busy  output  1  high from start acceptance through the EOP beat.
- done  output  1  one-cycle pulse after EOP is accepted.

## Operation
- All outputs are registered. Reset values: CONTROL=0, DATA=0, Valid=0, busy=0, done=0, sequence number=0, LFSR=16'hACE1.
- Beat transfer occurs on a CLK edge with Valid and ready both high. While Valid is high and ready is low, CONTROL and DATA hold stable.
- mode, pattern and len are latched when start is accepted. Later changes to them do not affect the frame in progress.
- FSM states: IDLE, TRAIN, HDR, PAY, EOP.
  - IDLE: Valid=0, CONTROL=0, DATA=0. start moves to TRAIN.
  - TRAIN: CONTROL=1,2,3,4 in order, each for TRAIN_REPS accepted beats, with DATA=0. Moves to HDR.
  - HDR: one beat, CONTROL=8, DATA = sequence number zero-extended. Moves to PAY, or to EOP if len=0.
  - PAY: len beats with CONTROL=9. Moves to EOP after the last beat is accepted.
  - EOP: one beat, CONTROL=0xF, DATA = latched len truncated/zero-extended to DATA_W. On acceptance: go to IDLE, pulse done, increment sequence number modulo 2^SEQ_W.
- Payload data by mode:
  - Increment (00): beat k carries pattern + k, modulo 2^DATA_W.
  - LFSR (01): 16-bit Fibonacci LFSR, reseeded to 16'hACE1 at start. DATA = lfsr[DATA_W-1:0]. Advances on each accepted PAY beat: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Fixed (10/11): every beat equals pattern.
- start while busy is ignored; no queuing.
- Reset asserted mid-frame: outputs drop to reset values asynchronously and the frame is abandoned. done does not pulse. The sequence number returns to 0.

## Timing
- start high at edge N in IDLE: busy=1 and the first TS1 beat (Valid=1) appear after edge N.
- With ready held high, frame length is 4·TRAIN_REPS + 1 + len + 1 cycles. The frame is back-to-back with no bubbles.
- done is high for exactly the cycle after the EOP acceptance edge. busy and Valid are 0 in that same cycle.
- Earliest next start is the cycle where done is high; that start is accepted.
- Reset deassertion is assumed synchronised externally; the first active edge after release sees IDLE.

## Configuration
- PCIE_TRAFFIC_LFSR_EN:
  - Defined: LFSR payload mode and its 16-bit register are compiled in.
  - Undefined: no LFSR logic exists, and mode 01 behaves exactly as increment mode (00).

## Test plan
- Basic frame: DATA_W=8, TRAIN_REPS=1, ready=1, start with mode=00, pattern=8'hAA, len=4 -> CONTROL 1,2,3,4,8,9,9,9,9,F. DATA 0,0,0,0,00,AA,AB,AC,AD,04. done one cycle later. Total 10 Valid cycles.
- Backpressure: same frame with ready low for 3 cycles during the second payload beat -> CONTROL=9/DATA=AB held for 3 cycles. Sequence otherwise identical. No beat lost or duplicated.
- LFSR, with macro defined: mode=01, len=3, DATA_W=16 -> payload ACE1, 59C3, B387. Macro undefined, pattern=0 -> payload 0000, 0001, 0002.
- Edge cases: len=0 -> header then EOP directly, EOP DATA=0. Second frame header DATA=1. After 256 frames with SEQ_W=8 -> header wraps to 0. Wrap of increment payload: pattern=8'hFE, len=3 -> FE, FF, 00.
- Reset mid-frame: assert reset during PAY -> Valid, busy, CONTROL and DATA go to 0 without waiting for an edge. No done pulse. Next frame header DATA=0.
- start while busy, plus TRAIN_REPS=2: extra start pulses mid-frame are ignored. Each TS symbol occupies 2 accepted beats.
